// File: rtl/operand_issue.sv
// Register-read / operand-issue stage: 32x32 register file, RAW/WAW scoreboard, registered ALU bundle.
// Optional writeback-to-operand bypass is enabled by defining OPERAND_ISSUE_BYPASS_EN.
`timescale 1ns/1ps
module operand_issue (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_type_inst,
  input  logic [5:0]         in_opcode,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [4:0]         in_rd,
  input  logic [15:0]        in_imm,
  input  logic               wb_en,
  input  logic [4:0]         wb_rd,
  input  logic [31:0]        wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         type_inst,
  output logic [5:0]         opcode,
  output logic [15:0]        imm,
  output logic [4:0]         rd,
  output logic signed [31:0] Rs1_val,
  output logic signed [31:0] Rs2_val
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.

  logic [31:0] rf [0:31];
  logic [31:0] pending;
  logic [31:0] pending_set;
  logic [31:0] pending_clr;

  logic use_rs1;
  logic use_rs2;
  logic writes_rd;
  logic wb_live;
  logic pend_rs1;
  logic pend_rs2;
  logic byp_rs1;
  logic byp_rs2;
  logic raw;
  logic waw;
  logic hazard;
  logic accept;
  logic [31:0] op1;
  logic [31:0] op2;

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (in_type_inst)
      2'b00: begin use_rs1 = 1'b1; writes_rd = 1'b1; end
      2'b01: begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
      2'b10: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default: ;
    endcase
  end

  assign wb_live  = wb_en && (wb_rd != 5'd0);
  assign pend_rs1 = (in_rs1 != 5'd0) && pending[in_rs1];
  assign pend_rs2 = (in_rs2 != 5'd0) && pending[in_rs2];

`ifdef OPERAND_ISSUE_BYPASS_EN
  // Forward only to a pending source; a non-pending source reads the pre-edge file.
  assign byp_rs1 = wb_live && (wb_rd == in_rs1) && pend_rs1;
  assign byp_rs2 = wb_live && (wb_rd == in_rs2) && pend_rs2;
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  // WAW ignores a same-cycle writeback so a set and a clear never hit one register.
  assign raw    = (use_rs1 && pend_rs1 && !byp_rs1) || (use_rs2 && pend_rs2 && !byp_rs2);
  assign waw    = writes_rd && (in_rd != 5'd0) && pending[in_rd];
  assign hazard = raw || waw;

  assign in_ready = (!out_valid || out_ready) && !hazard && reset_n;
  assign accept   = in_valid && in_ready;

  always_comb begin
    op1 = 32'd0;
    op2 = 32'd0;
    if (use_rs1) begin
      if (byp_rs1)              op1 = wb_data;
      else if (in_rs1 != 5'd0)  op1 = rf[in_rs1];
    end
    if (use_rs2) begin
      if (byp_rs2)              op2 = wb_data;
      else if (in_rs2 != 5'd0)  op2 = rf[in_rs2];
    end
  end

  always_comb begin
    pending_set = 32'd0;
    pending_clr = 32'd0;
    if (accept && writes_rd && (in_rd != 5'd0)) pending_set = 32'd1 << in_rd;
    if (wb_live)                                 pending_clr = 32'd1 << wb_rd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      pending   <= 32'd0;
      out_valid <= 1'b0;
      type_inst <= 2'd0;
      opcode    <= 6'd0;
      imm       <= 16'd0;
      rd        <= 5'd0;
      Rs1_val   <= 32'sd0;
      Rs2_val   <= 32'sd0;
    end else begin
      if (wb_live) rf[wb_rd] <= wb_data;
      pending <= (pending & ~pending_clr) | pending_set;
      if (accept) begin
        out_valid <= 1'b1;
        type_inst <= in_type_inst;
        opcode    <= in_opcode;
        imm       <= in_imm;
        rd        <= in_rd;
        Rs1_val   <= op1;
        Rs2_val   <= op2;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios then random traffic, checked against a
// register-file/scoreboard reference model; define OPERAND_ISSUE_BYPASS_EN to match the DUT build.
`timescale 1ns/1ps
module tb_operand_issue;

`ifdef OPERAND_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_type_inst = 2'b11;
  logic [5:0] in_opcode = '0;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic wb_en = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] type_inst;
  logic [5:0] opcode;
  logic [15:0] imm;
  logic [4:0] rd;
  logic signed [31:0] Rs1_val, Rs2_val;

  operand_issue dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_type_inst(in_type_inst), .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .type_inst(type_inst), .opcode(opcode),
    .imm(imm), .rd(rd), .Rs1_val(Rs1_val), .Rs2_val(Rs2_val)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_ov;
  logic [1:0]  m_type;
  logic [5:0]  m_op;
  logic [15:0] m_imm;
  logic [4:0]  m_rd;
  logic [31:0] m_r1, m_r2;
  bit          last_acc;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [1:0] t, output bit u1, output bit u2, output bit wr);
    u1 = (t != 2'b11);
    u2 = (t == 2'b01) || (t == 2'b10);
    wr = (t == 2'b00) || (t == 2'b01);
  endfunction

  function automatic bit forwarded(input logic [4:0] r);
    return BYP && wb_en && (wb_rd == r) && (r != 0) && m_pend[r];
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !forwarded(r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (forwarded(r)) return wb_data;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_pend[i] = 0; end
    m_ov = 0; m_type = 0; m_op = 0; m_imm = 0; m_rd = 0; m_r1 = 0; m_r2 = 0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after it.
  task automatic step();
    bit u1, u2, wr, haz, rdy;
    logic [31:0] o1, o2;
    @(negedge clk);
    decode(in_type_inst, u1, u2, wr);
    haz = (u1 && blocked(in_rs1)) || (u2 && blocked(in_rs2)) ||
          (wr && in_rd != 0 && m_pend[in_rd]);
    rdy = reset_n && (!m_ov || out_ready) && !haz;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    last_acc = in_valid && rdy;
    o1 = u1 ? operand(in_rs1) : 32'd0;
    o2 = u2 ? operand(in_rs2) : 32'd0;
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      if (last_acc) begin
        m_ov = 1; m_type = in_type_inst; m_op = in_opcode; m_imm = in_imm; m_rd = in_rd;
        m_r1 = o1; m_r2 = o2;
        if (wr && in_rd != 0) m_pend[in_rd] = 1;
      end else if (out_ready) m_ov = 0;
      if (wb_en && wb_rd != 0) begin m_rf[wb_rd] = wb_data; m_pend[wb_rd] = 0; end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("type_inst", {30'd0, type_inst}, {30'd0, m_type});
    chk("opcode", {26'd0, opcode}, {26'd0, m_op});
    chk("imm", {16'd0, imm}, {16'd0, m_imm});
    chk("rd", {27'd0, rd}, {27'd0, m_rd});
    chk("Rs1_val", Rs1_val, m_r1);
    chk("Rs2_val", Rs2_val, m_r2);
  endtask

  task automatic set_inst(input logic v, input logic [1:0] t, input logic [5:0] op,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                          input logic [15:0] im);
    in_valid = v; in_type_inst = t; in_opcode = op; in_rs1 = r1; in_rs2 = r2; in_rd = d; in_imm = im;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_en = en; wb_rd = r; wb_data = d;
  endtask

  initial begin
    int acc_cnt;
    int guard;
    logic [4:0] pend_list[$];
    model_reset();
    last_acc = 0;

    // Reset
    step(); step();
    reset_n = 1;

    // Basic R-type issue
    set_wb(1, 3, 32'd3); step();
    set_wb(1, 4, 32'd4); step();
    set_wb(0, 0, 0);
    set_inst(1, 2'b01, 6'h20, 5'd3, 5'd4, 5'd5, 16'h0000); step();
    chk("r_acc", {31'd0, last_acc}, 32'd1);
    chk("r_rs1", Rs1_val, 32'd3);
    chk("r_rs2", Rs2_val, 32'd4);
    chk("r_rd", {27'd0, rd}, 32'd5);

    // RAW on r5 while it is pending
    set_inst(1, 2'b01, 6'h21, 5'd5, 5'd4, 5'd8, 16'h0000);
    step(); chk("raw_stall0", {31'd0, last_acc}, 32'd0);
    step(); chk("raw_stall1", {31'd0, last_acc}, 32'd0);
    set_wb(1, 5, 32'hFFFFFFFC); step();
    chk("raw_wb_cycle", {31'd0, last_acc}, {31'd0, BYP});
    set_wb(0, 0, 0);
    if (!last_acc) step();
    chk("raw_issued", {31'd0, last_acc}, 32'd1);
    chk("raw_rs1", Rs1_val, 32'hFFFFFFFC);
    in_valid = 0;

    // r0 stays zero after a writeback to it
    set_wb(1, 0, 32'd7); step();
    set_wb(0, 0, 0);
    set_inst(1, 2'b00, 6'h05, 5'd0, 5'd3, 5'd9, 16'hFFFC); step();
    chk("i_rs1", Rs1_val, 32'd0);
    chk("i_rs2", Rs2_val, 32'd0);
    chk("i_imm", {16'd0, imm}, 32'h0000FFFC);

    // WAW on r6
    set_inst(1, 2'b00, 6'h06, 5'd0, 5'd0, 5'd6, 16'h0001); step();
    set_inst(1, 2'b00, 6'h07, 5'd0, 5'd0, 5'd6, 16'h0002); step();
    chk("waw_stall", {31'd0, last_acc}, 32'd0);
    set_wb(1, 6, 32'h66); step();
    chk("waw_wb_cycle", {31'd0, last_acc}, 32'd0);
    set_wb(0, 0, 0); step();
    chk("waw_after", {31'd0, last_acc}, 32'd1);

    // Backpressure
    set_inst(1, 2'b11, 6'h11, 5'd0, 5'd0, 5'd0, 16'h1111); step();
    set_inst(1, 2'b11, 6'h12, 5'd0, 5'd0, 5'd0, 16'h2222);
    out_ready = 0;
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_acc) acc_cnt++;
      chk("bp_hold_op", {26'd0, opcode}, 32'h11);
    end
    out_ready = 1; step();
    if (last_acc) acc_cnt++;
    chk("bp_accepts", acc_cnt, 32'd1);
    chk("bp_new_op", {26'd0, opcode}, 32'h12);
    in_valid = 0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && !last_acc)) begin
        set_inst($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 6'($urandom()),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 16'($urandom()));
      end
      pend_list.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) pend_list.push_back(5'(r));
      if (pend_list.size() != 0 && $urandom_range(0, 2) == 0)
        set_wb(1, pend_list[$urandom_range(0, pend_list.size() - 1)], $urandom());
      else
        set_wb(0, 5'($urandom()), $urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain the scoreboard
    in_valid = 0; out_ready = 1;
    guard = 0;
    while (guard < 40) begin
      pend_list.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) pend_list.push_back(5'(r));
      if (pend_list.size() == 0) break;
      set_wb(1, pend_list[0], 32'hA5A5_0000 | 32'(pend_list[0]));
      step();
      guard++;
    end
    set_wb(0, 0, 0);
    chk("drain_bound", {31'd0, guard < 40}, 32'd1);

    // Reset while r7 is pending and a bundle is held
    out_ready = 0;
    set_inst(1, 2'b00, 6'h0A, 5'd0, 5'd0, 5'd7, 16'h0007); step();
    chk("pre_reset_acc", {31'd0, last_acc}, 32'd1);
    in_valid = 0;
    reset_n = 0; step();
    chk("reset_ov", {31'd0, out_valid}, 32'd0);
    chk("reset_rd", {27'd0, rd}, 32'd0);
    reset_n = 1; out_ready = 1;
    set_inst(1, 2'b00, 6'h0B, 5'd7, 5'd0, 5'd0, 16'h0000); step();
    chk("post_reset_issue", {31'd0, last_acc}, 32'd1);
    chk("post_reset_rs1", Rs1_val, 32'd0);
    in_valid = 0; step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
# operand_issue

Register-read and operand-issue stage sitting directly upstream of the ALU. Accepts decoded instruction fields from the decoder, reads source operands from a 32 x 32-bit register file, and checks a per-register scoreboard for read-after-write and write-after-write hazards. Presents a registered operand bundle to the ALU through a valid/ready handshake. Also owns the register-file writeback port, which clears scoreboard entries.

## Interface
- No parameters. Fixed: 32 registers, 32-bit data, register 0 hardwired to zero.
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- in_type_inst  in  2  00 I-type, 01 R-type, 10 branch, 11 nop
- in_opcode  in  6  passed to ALU unchanged
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_imm  in  16  signed immediate, passed unchanged
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback register index
- wb_data  in  32  writeback value
- out_valid  out  1  ALU bundle valid
- out_ready  in  1  ALU consumes bundle
- type_inst, opcode, imm, rd  out  2/6/16/5  registered copies
- Rs1_val, Rs2_val  out  32 signed  registered operands

## Operation
- Operand use:
  - I-type reads rs1 and writes rd.
  - R-type reads rs1 and rs2, and writes rd.
  - Branch reads rs1 and rs2, and writes nothing.
  - Nop reads and writes nothing.
- An unused source drives 0 on its output (Rs2_val for I-type; both operands for nop).
- Register 0 reads as 0 and is never marked pending. Writeback with wb_rd = 0 is ignored.
- Scoreboard `pending[31:1]`:
  - Set on accept when the instruction writes rd and rd != 0.
  - Cleared on wb_en for wb_rd.
  - wb_en to a non-pending register still writes the register file and leaves the scoreboard unchanged.
- Hazard, evaluated combinationally:
  - RAW: any used source s has pending[s] and is not bypassed (see Configuration).
  - WAW: the instruction writes rd and pending[rd] is set, regardless of a same-cycle writeback to rd.
- `in_ready = (!out_valid || out_ready) && !hazard && reset_n`. in_ready is also computed when in_valid is low.
- Accept = in_valid && in_ready. On accept, the output register loads all fields and operands, and out_valid goes to 1.
- If out_ready is high and there is no accept, out_valid goes to 0.
- A writeback and a scoreboard set in the same cycle always target different registers, because WAW stalls.
- Register-file write on wb_en takes effect at the clock edge.
- On a read without bypass, the register file returns the pre-edge value.

## Timing
- Reset (reset_n low at an edge) clears:
  - all registers and all pending bits;
  - out_valid;
  - type_inst, opcode, imm, rd, Rs1_val, Rs2_val.
- in_ready is 0 while reset_n is low.
- Reset mid-operation drops the held bundle and all pending state.
- Latency: an instruction accepted at edge N has out_valid = 1 in the cycle after edge N. Throughput is 1 per cycle with no hazards.
- Backpressure: while out_valid && !out_ready, the outputs are held stable and in_ready is 0.
- A writeback at edge N is visible to a normal register read in the cycle after edge N.
- A stalled instruction must keep in_valid and its fields stable until accepted.

## Configuration
- `OPERAND_ISSUE_BYPASS_EN` defined:
  - If wb_en is high and wb_rd equals a used, pending source, that source is not a hazard.
  - The operand takes wb_data in the same cycle, so the instruction issues in the writeback cycle.
- Undefined:
  - No bypass; the source remains a hazard for the writeback cycle.
  - The instruction issues the cycle after the writeback and reads the updated register file, costing 1 extra stall cycle.

## Test plan
- Reset, then wb r3 = 3 and wb r4 = 4. Issue R-type opcode 0x20 with rs1 = 3, rs2 = 4, rd = 5 -> one cycle later out_valid = 1, Rs1_val = 3, Rs2_val = 4, rd = 5, and pending[5] is set.
- I-type with rs1 = 0, imm = 0xFFFC -> Rs1_val = 0, Rs2_val = 0, imm = 0xFFFC; reading r0 after wb r0 = 7 still gives 0.
- RAW: issue rd = 5, then immediately R-type rs1 = 5 -> in_ready = 0 until wb r5 = 0xFFFFFFFC.
  - With the macro: issues in the wb cycle with Rs1_val = -4.
  - Without the macro: issues in the next cycle with Rs1_val = -4.
- WAW: pending r6, new I-type rd = 6 -> stalls through the wb r6 cycle and is accepted the cycle after.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> outputs are held, in_ready = 0, and exactly one accept occurs after out_ready rises.
- Assert reset_n = 0 with pending r7 and out_valid = 1 -> next cycle out_valid = 0, all outputs 0, and a read of rs1 = 7 issues without stall with value 0.
